minterm_scanner: RTL and testbench

Sequential truth-table extractor: drives every input combination into a combinational function under test, samples its single output, builds the minterm mask and minterm count, then streams the minterm indices out over a valid/ready handshake. It recovers the minterm list of an `SoP`-style block from its behaviour. It sits in the guide testbenches between the stimulus control and the function under test, replacing hand-written exhaustive `#1` stimulus sequences.

---
 rtl/minterm_scanner.sv | 136 +++++++++++++
 tb/tb_minterm_scanner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/minterm_scanner.sv
// Truth-table extractor: scans every input vector, builds the minterm mask/count
// and streams minterm indices. Optional comparator enabled by `define SCAN_CHECK_EN.
module minterm_scanner #(
    parameter int N_VARS = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [N_VARS-1:0]     vec,
    input  logic                  s,
    output logic                  busy,
    output logic                  done,
    output logic [2**N_VARS-1:0]  mask,
    output logic [N_VARS:0]       count,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [N_VARS-1:0]     m_index,
    output logic                  m_last
`ifdef SCAN_CHECK_EN
    ,
    // 'expect' is a reserved word, so the reference mask port carries a suffix
    input  logic [2**N_VARS-1:0]  expect_mask,
    output logic                  mismatch
`endif
);

    localparam logic [N_VARS-1:0] LAST_IDX    = '1;
    localparam logic [31:0]       SETTLE_LAST = 32'(SETTLE - 1);
    localparam logic [N_VARS:0]   ONE         = (N_VARS+1)'(1);

    typedef enum logic [1:0] {IDLE, APPLY, EMIT} state_t;

    state_t            state;
    logic [N_VARS-1:0] idx;
    logic [N_VARS-1:0] ptr;
    logic [N_VARS:0]   emitted;
    logic [31:0]       settle;

    logic [N_VARS:0]   count_inc;
    logic [N_VARS:0]   emitted_nxt;
    logic [N_VARS-1:0] ptr_nxt;
    logic              advance;

    always_comb begin
        count_inc   = count + (N_VARS+1)'(s);
        advance     = (state == EMIT) && (!m_valid || m_ready);
        emitted_nxt = emitted + (N_VARS+1)'(m_valid && m_ready);
        ptr_nxt     = ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            ptr      <= '0;
            emitted  <= '0;
            settle   <= '0;
            vec      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mask     <= '0;
            count    <= '0;
            m_valid  <= 1'b0;
            m_index  <= '0;
            m_last   <= 1'b0;
`ifdef SCAN_CHECK_EN
            mismatch <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    vec  <= '0;
                    busy <= 1'b0;
                    if (start) begin
                        state    <= APPLY;
                        busy     <= 1'b1;
                        idx      <= '0;
                        settle   <= '0;
                        mask     <= '0;
                        count    <= '0;
`ifdef SCAN_CHECK_EN
                        mismatch <= 1'b0;
`endif
                    end
                end
                APPLY: begin
                    if (settle == SETTLE_LAST) begin
                        settle     <= '0;
                        mask[idx]  <= s;
                        count      <= count_inc;
                        if (idx == LAST_IDX) begin
                            // Preload the first beat so the stream outputs stay registered
                            state   <= EMIT;
                            vec     <= '0;
                            ptr     <= '0;
                            emitted <= '0;
                            m_valid <= mask[0];
                            m_index <= '0;
                            m_last  <= mask[0] && (count_inc == ONE);
                        end else begin
                            idx <= idx + 1'b1;
                            vec <= idx + 1'b1;
                        end
                    end else begin
                        settle <= settle + 32'd1;
                    end
                end
                EMIT: begin
                    if (advance) begin
                        if (ptr == LAST_IDX) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            m_valid  <= 1'b0;
                            m_index  <= '0;
                            m_last   <= 1'b0;
`ifdef SCAN_CHECK_EN
                            mismatch <= (mask != expect_mask);
`endif
                        end else begin
                            ptr     <= ptr_nxt;
                            emitted <= emitted_nxt;
                            m_valid <= mask[ptr_nxt];
                            m_index <= ptr_nxt;
                            m_last  <= mask[ptr_nxt] && ((emitted_nxt + ONE) == count);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_scanner.sv
// Randomized self-checking bench: two scanners (SETTLE=1 and SETTLE=2) driven
// by truth tables, checked against a queue-based reference of the minterm list.
module tb_minterm_scanner;

    localparam int N = 4;
    localparam int SZ = 16;
    localparam logic [15:0] SOP = 16'h02AB;

    logic        clk = 1'b0;
    logic        reset;
    logic        start   [2];
    logic        m_ready [2];
    logic        s       [2];
    logic [3:0]  vec     [2];
    logic        busy    [2];
    logic        done    [2];
    logic [15:0] mask    [2];
    logic [4:0]  count   [2];
    logic        m_valid [2];
    logic [3:0]  m_index [2];
    logic        m_last  [2];
    logic [15:0] lut     [2];
`ifdef SCAN_CHECK_EN
    logic [15:0] exp_mask [2];
    logic        mismatch [2];
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign s[0] = lut[0][vec[0]];
    assign s[1] = lut[1][vec[1]];

    minterm_scanner #(.N_VARS(N), .SETTLE(1)) u_s1 (
        .clk(clk), .reset(reset), .start(start[0]), .vec(vec[0]), .s(s[0]),
        .busy(busy[0]), .done(done[0]), .mask(mask[0]), .count(count[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_index(m_index[0]), .m_last(m_last[0])
`ifdef SCAN_CHECK_EN
        , .expect_mask(exp_mask[0]), .mismatch(mismatch[0])
`endif
    );

    minterm_scanner #(.N_VARS(N), .SETTLE(2)) u_s2 (
        .clk(clk), .reset(reset), .start(start[1]), .vec(vec[1]), .s(s[1]),
        .busy(busy[1]), .done(done[1]), .mask(mask[1]), .count(count[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_index(m_index[1]), .m_last(m_last[1])
`ifdef SCAN_CHECK_EN
        , .expect_mask(exp_mask[1]), .mismatch(mismatch[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // mode: 0 = ready always high, 1 = stall 3 cycles on index stall_idx, 2 = random ready
    task automatic scan(input int d, input logic [15:0] f, input int mode, input int stall_idx,
                        input bit poke_start, input logic [15:0] ref_mask);
        int q[$];
        int settle_cycles;
        int pop;
        int stalls;
        int stall_left;
        int c;
        bit finished;
        bit prev_stall;
        logic [3:0] prev_idx;
        bit rdy;
        settle_cycles = d + 1;
        pop = 0;
        for (int i = 0; i < SZ; i++) if (f[i]) begin q.push_back(i); pop++; end
        lut[d] = f;
`ifdef SCAN_CHECK_EN
        exp_mask[d] = ref_mask;
`endif
        stalls = 0; stall_left = 3; finished = 0; prev_stall = 0; prev_idx = '0;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        for (c = 1; c < 300 && !finished; c++) begin
            check("busy_and_done", 32'(busy[d] & done[d]), 0);
            if (c <= SZ * settle_cycles) begin
                check("apply_vec", 32'(vec[d]), 32'((c - 1) / settle_cycles));
                check("apply_busy", 32'(busy[d]), 1);
            end
            if (prev_stall) begin
                check("stall_valid_held", 32'(m_valid[d]), 1);
                check("stall_index_held", 32'(m_index[d]), 32'(prev_idx));
            end
            if (done[d]) begin
                check("done_cycle", c, SZ * (settle_cycles + 1) + 1 + stalls);
                check("mask", 32'(mask[d]), 32'(f));
                check("count", 32'(count[d]), pop);
                check("beats_left", q.size(), 0);
`ifdef SCAN_CHECK_EN
                check("mismatch", 32'(mismatch[d]), 32'(ref_mask != f));
`endif
                finished = 1;
            end else begin
                rdy = 1'b1;
                if (mode == 1 && m_valid[d] && m_index[d] == 4'(stall_idx) && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else if (mode == 2) begin
                    rdy = ($urandom_range(3) != 0);
                end
                m_ready[d] = rdy;
                prev_stall = m_valid[d] && !rdy;
                prev_idx = m_index[d];
                if (prev_stall) stalls++;
                if (m_valid[d] && rdy) begin
                    if (q.size() == 0) begin
                        check("unexpected_beat", 32'(m_index[d]), 32'hFFFF);
                    end else begin
                        check("beat_index", 32'(m_index[d]), 32'(q[0]));
                        check("beat_last", 32'(m_last[d]), 32'(q.size() == 1));
                        void'(q.pop_front());
                    end
                end
                start[d] = poke_start && (c == 20);
                @(negedge clk);
            end
        end
        if (!finished) check("done_timeout", 0, 1);
        m_ready[d] = 1'b1;
        start[d] = 1'b0;
        @(negedge clk);
        check("idle_after_done", 32'(busy[d]), 0);
    endtask

    initial begin
        logic [15:0] f;
        int d;
        bit found;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; m_ready[i] = 1'b1; lut[i] = '0;
`ifdef SCAN_CHECK_EN
            exp_mask[i] = '0;
`endif
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_busy", 32'(busy[i]), 0);
            check("rst_vec", 32'(vec[i]), 0);
            check("rst_mask_count", {11'd0, count[i], mask[i]}, 0);
            check("rst_stream", {m_valid[i], m_last[i], m_index[i]}, 0);
            check("rst_done", 32'(done[i]), 0);
        end
        reset = 1'b0;
        @(negedge clk);

        scan(0, SOP, 0, 0, 0, SOP);
        scan(0, 16'h0000, 0, 0, 0, 16'h0000);
        scan(1, 16'hFFFF, 0, 0, 0, 16'hFFFF);
        scan(0, SOP, 1, 3, 1, 16'h02AA);

        // Reset while vec=7 mid-scan, then a clean rescan
        lut[0] = SOP;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (vec[0] == 4'd7) found = 1;
            else @(negedge clk);
        end
        check("reached_vec7", 32'(found), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 32'(busy[0]), 0);
        check("midrst_vec", 32'(vec[0]), 0);
        check("midrst_mask", 32'(mask[0]), 0);
        check("midrst_count", 32'(count[0]), 0);
        scan(0, SOP, 0, 0, 0, SOP);

        for (int k = 0; k < 8; k++) begin
            f = 16'($urandom);
            d = k % 2;
            scan(d, f, 2, 0, 0, (k % 3 == 0) ? ~f : f);
        end
        scan(1, 16'h8001, 2, 0, 0, 16'h8001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
